// File: rtl/ddr_lane_dly_tap_ctrl.sv
//-----------------------------------------------------------------------------
// ddr_lane_dly_tap_ctrl
//   TX delay-line tap sequencer for DDR PHY lane IODs (DQ/DM/DQS).
//   Accepts one "set lane N to tap T" command at a time, optionally pulses
//   LOAD first, then walks the tap one step at a time with SETUP/MOVE/GAP
//   timing. A shadow tap per lane mirrors the IOD state.
//
//   Ports:
//     fab_clk, arst_n           clock, async active-low reset
//     cmd_valid/cmd_ready       command handshake
//     cmd_lane/load/target      command payload
//     rsp_valid/err/tap         one-cycle completion strobe + status
//     busy                      FSM not idle
//     delay_line_load/direction/move   per-lane IOD controls
//     delay_line_out_of_range   per-lane IOD range flag
//
//   Configuration macro: DLY_CTRL_OOR_ABORT_EN
//     defined   -> an out-of-range sample during GAP ends the command
//     undefined -> stepping continues, error reported at completion
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module ddr_lane_dly_tap_ctrl #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned TAP_W     = 8,
  parameter int unsigned MAX_TAP   = 127,
  parameter int unsigned RESET_TAP = 1,
  parameter int unsigned MOVE_GAP  = 2,
  localparam int unsigned LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 fab_clk,
  input  logic                 arst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LANE_W-1:0]    cmd_lane,
  input  logic                 cmd_load,
  input  logic [TAP_W-1:0]     cmd_target,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [TAP_W-1:0]     rsp_tap,
  output logic                 busy,
  output logic [NUM_LANES-1:0] delay_line_load,
  output logic [NUM_LANES-1:0] delay_line_direction,
  output logic [NUM_LANES-1:0] delay_line_move,
  input  logic [NUM_LANES-1:0] delay_line_out_of_range
);

  localparam int unsigned GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_MOVE,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [TAP_W-1:0]   target_q, target_d;
  logic               dir_q, dir_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               oor_q, oor_d;
  logic [TAP_W-1:0]   shadow_q [NUM_LANES];

  logic                 accept;
  logic [LANE_W-1:0]    cur_lane;
  logic [TAP_W-1:0]     cur_target;
  logic                 lane_ok;
  logic [TAP_W-1:0]     cur_tap;
  logic [TAP_W-1:0]     tap_nx;
  logic                 oor_now;
  logic [NUM_LANES-1:0] lane_onehot;

  logic                 ready_d, busy_d, rsp_valid_d, rsp_err_d;
  logic [TAP_W-1:0]     rsp_tap_d;
  logic [NUM_LANES-1:0] load_d, move_d, dir_bus_d;

  // Next-state, shadow update value and next registered outputs
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    target_d  = target_q;
    dir_d     = dir_q;
    gap_d     = gap_q;
    oor_d     = oor_q;
    rsp_err_d = 1'b0;
    rsp_tap_d = '0;

    accept     = cmd_valid & cmd_ready & (state_q == S_IDLE);
    cur_lane   = (state_q == S_IDLE) ? cmd_lane : lane_q;
    cur_target = (state_q == S_IDLE) ? cmd_target : target_q;
    lane_ok    = (32'(cur_lane) < NUM_LANES);
    cur_tap    = lane_ok ? shadow_q[cur_lane] : '0;
    oor_now    = (state_q == S_GAP) & lane_ok & delay_line_out_of_range[cur_lane];
    tap_nx     = cur_tap;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lane_d   = cmd_lane;
          target_d = cmd_target;
          oor_d    = 1'b0;
          dir_d    = 1'b0;
          gap_d    = '0;
          if (!lane_ok || (32'(cmd_target) > MAX_TAP)) begin
            state_d   = S_DONE;
            rsp_err_d = 1'b1;
            rsp_tap_d = cur_tap;
          end else if (cmd_load) begin
            state_d = S_LOAD;
          end else if (cur_tap == cmd_target) begin
            state_d   = S_DONE;
            rsp_tap_d = cur_tap;
          end else begin
            state_d = S_SETUP;
            dir_d   = (cmd_target > cur_tap);
          end
        end
      end
      S_LOAD: begin
        tap_nx = TAP_W'(RESET_TAP);
        if (tap_nx == cur_target) begin
          state_d   = S_DONE;
          rsp_tap_d = tap_nx;
        end else begin
          state_d = S_SETUP;
          dir_d   = (cur_target > tap_nx);
        end
      end
      S_SETUP: begin
        state_d = S_MOVE;
      end
      S_MOVE: begin
        tap_nx  = dir_q ? (cur_tap + TAP_W'(1)) : (cur_tap - TAP_W'(1));
        state_d = S_GAP;
        gap_d   = '0;
      end
      S_GAP: begin
        oor_d = oor_q | oor_now;
`ifdef DLY_CTRL_OOR_ABORT_EN
        if (oor_now) begin
          state_d   = S_DONE;
          rsp_err_d = 1'b1;
          rsp_tap_d = cur_tap;
        end else
`endif
        if (gap_q == GAP_W'(MOVE_GAP - 1)) begin
          if (cur_tap == cur_target) begin
            state_d   = S_DONE;
            rsp_err_d = oor_q | oor_now;
            rsp_tap_d = cur_tap;
          end else begin
            state_d = S_SETUP;
            dir_d   = (cur_target > cur_tap);
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Direction is only meaningful while stepping
    if (state_d == S_DONE || state_d == S_IDLE) begin
      dir_d = 1'b0;
    end

    // Only states reached with a valid lane drive lane bits
    lane_onehot = NUM_LANES'(1) << lane_d;
    load_d      = (state_d == S_LOAD) ? lane_onehot : '0;
    move_d      = (state_d == S_MOVE) ? lane_onehot : '0;
    dir_bus_d   = dir_d ? lane_onehot : '0;
    ready_d     = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q              <= S_IDLE;
      lane_q               <= '0;
      target_q             <= '0;
      dir_q                <= 1'b0;
      gap_q                <= '0;
      oor_q                <= 1'b0;
      cmd_ready            <= 1'b0;
      busy                 <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_err              <= 1'b0;
      rsp_tap              <= '0;
      delay_line_load      <= '0;
      delay_line_move      <= '0;
      delay_line_direction <= '0;
    end else begin
      state_q              <= state_d;
      lane_q               <= lane_d;
      target_q             <= target_d;
      dir_q                <= dir_d;
      gap_q                <= gap_d;
      oor_q                <= oor_d;
      cmd_ready            <= ready_d;
      busy                 <= busy_d;
      rsp_valid            <= rsp_valid_d;
      rsp_err              <= rsp_err_d;
      rsp_tap              <= rsp_tap_d;
      delay_line_load      <= load_d;
      delay_line_move      <= move_d;
      delay_line_direction <= dir_bus_d;
    end
  end

  // Per-lane shadow taps, updated at the end of LOAD and MOVE
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        shadow_q[i] <= TAP_W'(RESET_TAP);
      end
    end else if (state_q == S_LOAD || state_q == S_MOVE) begin
      shadow_q[lane_q] <= tap_nx;
    end
  end

endmodule
